// File: rtl/stump_pkg.sv
// ----------------------------------------------------------------------------
// stump_pkg
// Shared definitions for the Stump operand-select pipeline: select-width
// helper, operand-source indices and the skid fill-state encoding.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package stump_pkg;

  // Operand-source indices on the datapath mux inputs
  localparam int SRC_REG = 0;
  localparam int SRC_IMM = 1;
  localparam int SRC_PC  = 2;
  localparam int SRC_MEM = 3;

  // Select width for an n-way mux: ceil(log2(n)), never below one bit so a
  // degenerate configuration still has a real select port.
  function automatic int sel_width(input int n);
    int w;
    w = $clog2(n);
    if (w < 1) begin
      w = 1;
    end
    return w;
  endfunction

  // Occupancy of the output stage when the skid entry is present
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } fill_state_t;

endpackage

`default_nettype wire

// File: rtl/stump_mux_pipe_if.sv
// ----------------------------------------------------------------------------
// stump_mux_pipe_if
// Upstream (data + select + valid/ready) and downstream (q + valid/ready +
// select error) signals of the pipelined selector.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface stump_mux_pipe_if
  import stump_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int N_INPUTS = 2
);

  localparam int SEL_W = sel_width(N_INPUTS);

  logic [N_INPUTS*WIDTH-1:0] d_flat;
  logic [SEL_W-1:0]          sel;
  logic                      in_valid;
  logic                      in_ready;
  logic [WIDTH-1:0]          q;
  logic                      out_valid;
  logic                      out_ready;
  logic                      sel_err;

  // Traffic generator / testbench side: offers items, consumes results
  modport master (
    output d_flat,
    output sel,
    output in_valid,
    input  in_ready,
    input  q,
    input  out_valid,
    output out_ready,
    input  sel_err
  );

  // Selector side
  modport slave (
    input  d_flat,
    input  sel,
    input  in_valid,
    output in_ready,
    output q,
    output out_valid,
    input  out_ready,
    output sel_err
  );

endinterface

`default_nettype wire

// File: rtl/stump_mux_nway.sv
// ----------------------------------------------------------------------------
// stump_mux_nway
// Combinational N-way, WIDTH-bit indexed select with range check. An
// out-of-range select yields zero data and raises err_o; the select is
// compared at full width, never truncated or wrapped.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module stump_mux_nway
  import stump_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int N_INPUTS = 2,
  parameter int SEL_W    = sel_width(N_INPUTS)
) (
  input  wire logic [N_INPUTS*WIDTH-1:0] d_flat_i,
  input  wire logic [SEL_W-1:0]          sel_i,
  output logic      [WIDTH-1:0]          data_o,
  output logic                           err_o
);

  // Indexed select; falls through to zero when no input index matches
  always_comb begin
    data_o = '0;
    for (int i = 0; i < N_INPUTS; i++) begin
      if (32'(sel_i) == 32'(i)) begin
        data_o = d_flat_i[i*WIDTH +: WIDTH];
      end
    end
  end

  assign err_o = (32'(sel_i) >= 32'(N_INPUTS));

endmodule

`default_nettype wire

// File: rtl/stump_mux_pipe.sv
// ----------------------------------------------------------------------------
// stump_mux_pipe
// Parametrised N-way, WIDTH-bit selector with a registered output stage and
// valid/ready handshake, placed between Stump operand sources and the ALU or
// address path. Out-of-range selects produce zero data with sel_err set.
// Build option: STUMP_MUX_PIPE_SKID_EN adds a one-entry skid buffer and makes
// in_ready a registered signal (!skid_full). Without it, in_ready is
// combinational: !out_valid | out_ready.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module stump_mux_pipe
  import stump_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int N_INPUTS = 2
) (
  input wire logic          clk,
  input wire logic          rst_n,
  stump_mux_pipe_if.slave   bus
);

  localparam int SEL_W = sel_width(N_INPUTS);

  logic [WIDTH-1:0] mux_data;
  logic             mux_err;
  logic             in_ready_w;
  logic             in_xfer;
  logic             out_xfer;

  logic [WIDTH-1:0] q_q;
  logic             err_q;
  logic             out_valid_q;

  stump_mux_nway #(
    .WIDTH    (WIDTH),
    .N_INPUTS (N_INPUTS),
    .SEL_W    (SEL_W)
  ) u_nway (
    .d_flat_i (bus.d_flat),
    .sel_i    (bus.sel),
    .data_o   (mux_data),
    .err_o    (mux_err)
  );

  assign in_xfer  = bus.in_valid & in_ready_w;
  assign out_xfer = out_valid_q & bus.out_ready;

`ifdef STUMP_MUX_PIPE_SKID_EN

  fill_state_t      state_q;
  logic [WIDTH-1:0] skid_data_q;
  logic             skid_err_q;
  logic             in_ready_q;

  // Fill-state machine: q is always refilled from the skid entry before any
  // new input, so ordering is preserved; in_ready_q tracks !skid_full.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_EMPTY;
      q_q         <= '0;
      err_q       <= 1'b0;
      out_valid_q <= 1'b0;
      skid_data_q <= '0;
      skid_err_q  <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_xfer) begin
            q_q         <= mux_data;
            err_q       <= mux_err;
            out_valid_q <= 1'b1;
            state_q     <= ST_ONE;
          end
        end
        ST_ONE: begin
          if (in_xfer && out_xfer) begin
            q_q   <= mux_data;
            err_q <= mux_err;
          end else if (in_xfer) begin
            // q is stalled: park the new item in the skid entry
            skid_data_q <= mux_data;
            skid_err_q  <= mux_err;
            in_ready_q  <= 1'b0;
            state_q     <= ST_TWO;
          end else if (out_xfer) begin
            out_valid_q <= 1'b0;
            state_q     <= ST_EMPTY;
          end
        end
        ST_TWO: begin
          // in_ready_q is low here, so only the output side can move
          if (out_xfer) begin
            q_q        <= skid_data_q;
            err_q      <= skid_err_q;
            in_ready_q <= 1'b1;
            state_q    <= ST_ONE;
          end
        end
        default: begin
          state_q     <= ST_EMPTY;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready_w = in_ready_q;

`else

  assign in_ready_w = !out_valid_q | bus.out_ready;

  // Single output register: load on accept, drain on consume, hold otherwise
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q_q         <= '0;
      err_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else if (in_xfer) begin
      q_q         <= mux_data;
      err_q       <= mux_err;
      out_valid_q <= 1'b1;
    end else if (out_xfer) begin
      out_valid_q <= 1'b0;
    end
  end

`endif

  assign bus.in_ready  = in_ready_w;
  assign bus.q         = q_q;
  assign bus.sel_err   = err_q;
  assign bus.out_valid = out_valid_q;

endmodule

`default_nettype wire
